mmu_req_arbiter: RTL and testbench

MMU_REQ_ARBITER -- requirements
Module: mmu_req_arbiter

---
 rtl/mmu_req_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mmu_req_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_req_arbiter.sv
// rtl/mmu_req_arbiter.sv - two-client round-robin arbiter for MMU alloc/free request FIFOs
// Tracks issue order per channel so MMU responses are steered back to the requesting client.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef REQ_SIZE_TYPE_WIDTH
`define REQ_SIZE_TYPE_WIDTH 2
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 10
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 2
`endif

module mmu_req_arbiter #(
  parameter int ORDER_DEPTH = 8,
  parameter int ORDER_PTR   = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [1:0]                           cli_alloc_valid,
  output logic [1:0]                           cli_alloc_ready,
  input  logic [2*`REQ_ID_WIDTH-1:0]           cli_alloc_id,
  input  logic [2*`REQ_SIZE_TYPE_WIDTH-1:0]    cli_alloc_page_count,
  input  logic [1:0]                           cli_free_valid,
  output logic [1:0]                           cli_free_ready,
  input  logic [2*`REQ_ID_WIDTH-1:0]           cli_free_id,
  input  logic [2*`ALL_PAGE_IDX_WIDTH-1:0]     cli_free_page_idx,
  input  logic [2*`REQ_SIZE_TYPE_WIDTH-1:0]    cli_free_page_count,
  output logic                                 alloc_fifo_push,
  output logic [`REQ_ID_WIDTH-1:0]             alloc_fifo_id,
  output logic [`REQ_SIZE_TYPE_WIDTH-1:0]      alloc_fifo_page_count,
  input  logic                                 alloc_fifo_full,
  output logic                                 free_fifo_push,
  output logic [`REQ_ID_WIDTH-1:0]             free_fifo_id,
  output logic [`ALL_PAGE_IDX_WIDTH-1:0]       free_fifo_page_idx,
  output logic [`REQ_SIZE_TYPE_WIDTH-1:0]      free_fifo_page_count,
  input  logic                                 free_fifo_full,
  input  logic                                 alloc_rsp_write_en,
  input  logic [`REQ_ID_WIDTH-1:0]             alloc_rsp_id,
  input  logic [`ALL_PAGE_IDX_WIDTH-1:0]       alloc_rsp_page_idx,
  input  logic                                 alloc_rsp_fail,
  input  logic [`FAIL_REASON_WIDTH-1:0]        alloc_rsp_fail_reason,
  input  logic                                 free_rsp_write_en,
  input  logic [`REQ_ID_WIDTH-1:0]             free_rsp_id,
  input  logic                                 free_rsp_fail,
  input  logic [`FAIL_REASON_WIDTH-1:0]        free_rsp_fail_reason,
  output logic [1:0]                           cli_alloc_rsp_valid,
  output logic [1:0]                           cli_free_rsp_valid,
  output logic [`REQ_ID_WIDTH-1:0]             rsp_id,
  output logic [`ALL_PAGE_IDX_WIDTH-1:0]       rsp_page_idx,
  output logic                                 rsp_fail,
  output logic [`FAIL_REASON_WIDTH-1:0]        rsp_fail_reason,
  output logic [ORDER_PTR:0]                   alloc_outstanding,
  output logic [ORDER_PTR:0]                   free_outstanding,
  output logic                                 rsp_orphan_err
);

  localparam int IW = `REQ_ID_WIDTH;
  localparam int SW = `REQ_SIZE_TYPE_WIDTH;
  localparam int PW = `ALL_PAGE_IDX_WIDTH;
  localparam int FW = `FAIL_REASON_WIDTH;
  localparam logic [ORDER_PTR:0] DEPTH_C = (ORDER_PTR+1)'(ORDER_DEPTH);

  logic                   r_alloc_rr, r_free_rr;
  logic [ORDER_DEPTH-1:0] r_alloc_ord, r_free_ord;
  logic [ORDER_PTR-1:0]   r_alloc_wr, r_alloc_rd, r_free_wr, r_free_rd;
  logic [ORDER_PTR:0]     r_alloc_cnt, r_free_cnt;
  logic                   r_skid_vld, r_skid_idx, r_skid_fail;
  logic [IW-1:0]          r_skid_id;
  logic [FW-1:0]          r_skid_reason;
  logic [1:0]             r_alloc_strb, r_free_strb;
  logic [IW-1:0]          r_rsp_id;
  logic [PW-1:0]          r_rsp_page_idx;
  logic                   r_rsp_fail, r_orphan;
  logic [FW-1:0]          r_rsp_reason;

  logic w_alloc_can, w_alloc_gnt, w_alloc_sel;
  logic w_free_can, w_free_gnt, w_free_sel;
  logic w_alloc_pop, w_free_pop, w_alloc_orph, w_free_orph;
  logic w_alloc_pidx, w_free_pidx;

  // occupancy check deliberately ignores a same-cycle pop
  assign w_alloc_can = !alloc_fifo_full && (r_alloc_cnt < DEPTH_C);
  assign w_free_can  = !free_fifo_full  && (r_free_cnt  < DEPTH_C);

  always_comb begin
    w_alloc_gnt = 1'b0;
    w_alloc_sel = r_alloc_rr;
    if (w_alloc_can) begin
      if (cli_alloc_valid[r_alloc_rr]) begin
        w_alloc_gnt = 1'b1;
        w_alloc_sel = r_alloc_rr;
      end else if (cli_alloc_valid[~r_alloc_rr]) begin
        w_alloc_gnt = 1'b1;
        w_alloc_sel = ~r_alloc_rr;
      end
    end
    w_free_gnt = 1'b0;
    w_free_sel = r_free_rr;
    if (w_free_can) begin
      if (cli_free_valid[r_free_rr]) begin
        w_free_gnt = 1'b1;
        w_free_sel = r_free_rr;
      end else if (cli_free_valid[~r_free_rr]) begin
        w_free_gnt = 1'b1;
        w_free_sel = ~r_free_rr;
      end
    end
  end

  assign cli_alloc_ready       = w_alloc_gnt ? (2'b01 << w_alloc_sel) : 2'b00;
  assign alloc_fifo_push       = w_alloc_gnt;
  assign alloc_fifo_id         = w_alloc_gnt ? cli_alloc_id[w_alloc_sel*IW +: IW] : '0;
  assign alloc_fifo_page_count = w_alloc_gnt ? cli_alloc_page_count[w_alloc_sel*SW +: SW] : '0;
  assign cli_free_ready        = w_free_gnt ? (2'b01 << w_free_sel) : 2'b00;
  assign free_fifo_push        = w_free_gnt;
  assign free_fifo_id          = w_free_gnt ? cli_free_id[w_free_sel*IW +: IW] : '0;
  assign free_fifo_page_idx    = w_free_gnt ? cli_free_page_idx[w_free_sel*PW +: PW] : '0;
  assign free_fifo_page_count  = w_free_gnt ? cli_free_page_count[w_free_sel*SW +: SW] : '0;

  assign w_alloc_pop  = alloc_rsp_write_en && (r_alloc_cnt != '0);
  assign w_alloc_orph = alloc_rsp_write_en && (r_alloc_cnt == '0);
  assign w_free_pop   = free_rsp_write_en  && (r_free_cnt != '0);
  assign w_free_orph  = free_rsp_write_en  && (r_free_cnt == '0);
  assign w_alloc_pidx = r_alloc_ord[r_alloc_rd];
  assign w_free_pidx  = r_free_ord[r_free_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_rr  <= 1'b0;
      r_alloc_ord <= '0;
      r_alloc_wr  <= '0;
      r_alloc_rd  <= '0;
      r_alloc_cnt <= '0;
      r_free_rr   <= 1'b0;
      r_free_ord  <= '0;
      r_free_wr   <= '0;
      r_free_rd   <= '0;
      r_free_cnt  <= '0;
    end else begin
      if (w_alloc_gnt) begin
        r_alloc_ord[r_alloc_wr] <= w_alloc_sel;
        r_alloc_wr              <= r_alloc_wr + ORDER_PTR'(1);
        r_alloc_rr              <= ~w_alloc_sel;
      end
      if (w_alloc_pop) r_alloc_rd <= r_alloc_rd + ORDER_PTR'(1);
      if (w_alloc_gnt && !w_alloc_pop)      r_alloc_cnt <= r_alloc_cnt + (ORDER_PTR+1)'(1);
      else if (!w_alloc_gnt && w_alloc_pop) r_alloc_cnt <= r_alloc_cnt - (ORDER_PTR+1)'(1);

      if (w_free_gnt) begin
        r_free_ord[r_free_wr] <= w_free_sel;
        r_free_wr             <= r_free_wr + ORDER_PTR'(1);
        r_free_rr             <= ~w_free_sel;
      end
      if (w_free_pop) r_free_rd <= r_free_rd + ORDER_PTR'(1);
      if (w_free_gnt && !w_free_pop)      r_free_cnt <= r_free_cnt + (ORDER_PTR+1)'(1);
      else if (!w_free_gnt && w_free_pop) r_free_cnt <= r_free_cnt - (ORDER_PTR+1)'(1);
    end
  end

  // alloc wins the shared payload; a parked free response goes out before any new one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_strb   <= 2'b00;
      r_free_strb    <= 2'b00;
      r_rsp_id       <= '0;
      r_rsp_page_idx <= '0;
      r_rsp_fail     <= 1'b0;
      r_rsp_reason   <= '0;
      r_skid_vld     <= 1'b0;
      r_skid_idx     <= 1'b0;
      r_skid_id      <= '0;
      r_skid_fail    <= 1'b0;
      r_skid_reason  <= '0;
      r_orphan       <= 1'b0;
    end else begin
      r_alloc_strb <= 2'b00;
      r_free_strb  <= 2'b00;
      if (w_alloc_pop) begin
        r_alloc_strb   <= 2'b01 << w_alloc_pidx;
        r_rsp_id       <= alloc_rsp_id;
        r_rsp_page_idx <= alloc_rsp_page_idx;
        r_rsp_fail     <= alloc_rsp_fail;
        r_rsp_reason   <= alloc_rsp_fail_reason;
      end else if (r_skid_vld) begin
        r_free_strb    <= 2'b01 << r_skid_idx;
        r_rsp_id       <= r_skid_id;
        r_rsp_page_idx <= '0;
        r_rsp_fail     <= r_skid_fail;
        r_rsp_reason   <= r_skid_reason;
      end else if (w_free_pop) begin
        r_free_strb    <= 2'b01 << w_free_pidx;
        r_rsp_id       <= free_rsp_id;
        r_rsp_page_idx <= '0;
        r_rsp_fail     <= free_rsp_fail;
        r_rsp_reason   <= free_rsp_fail_reason;
      end

      if (w_free_pop && (w_alloc_pop || r_skid_vld)) begin
        r_skid_vld    <= 1'b1;
        r_skid_idx    <= w_free_pidx;
        r_skid_id     <= free_rsp_id;
        r_skid_fail   <= free_rsp_fail;
        r_skid_reason <= free_rsp_fail_reason;
      end else if (r_skid_vld && !w_alloc_pop) begin
        r_skid_vld <= 1'b0;
      end

      if (w_alloc_orph || w_free_orph) r_orphan <= 1'b1;
    end
  end

  assign cli_alloc_rsp_valid = r_alloc_strb;
  assign cli_free_rsp_valid  = r_free_strb;
  assign rsp_id              = r_rsp_id;
  assign rsp_page_idx        = r_rsp_page_idx;
  assign rsp_fail            = r_rsp_fail;
  assign rsp_fail_reason     = r_rsp_reason;
  assign alloc_outstanding   = r_alloc_cnt;
  assign free_outstanding    = r_free_cnt;
  assign rsp_orphan_err      = r_orphan;

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// tb/tb_mmu_req_arbiter.sv - directed self-checking bench for mmu_req_arbiter
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef REQ_SIZE_TYPE_WIDTH
`define REQ_SIZE_TYPE_WIDTH 2
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 10
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 2
`endif

module tb_mmu_req_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]  cli_alloc_valid, cli_alloc_ready, cli_free_valid, cli_free_ready;
  logic [15:0] cli_alloc_id, cli_free_id;
  logic [3:0]  cli_alloc_page_count, cli_free_page_count;
  logic [19:0] cli_free_page_idx;
  logic        alloc_fifo_push, alloc_fifo_full, free_fifo_push, free_fifo_full;
  logic [7:0]  alloc_fifo_id, free_fifo_id;
  logic [1:0]  alloc_fifo_page_count, free_fifo_page_count;
  logic [9:0]  free_fifo_page_idx;
  logic        alloc_rsp_write_en, alloc_rsp_fail, free_rsp_write_en, free_rsp_fail;
  logic [7:0]  alloc_rsp_id, free_rsp_id, rsp_id;
  logic [9:0]  alloc_rsp_page_idx, rsp_page_idx;
  logic [1:0]  alloc_rsp_fail_reason, free_rsp_fail_reason, rsp_fail_reason;
  logic [1:0]  cli_alloc_rsp_valid, cli_free_rsp_valid;
  logic        rsp_fail, rsp_orphan_err;
  logic [3:0]  alloc_outstanding, free_outstanding;

  int n_checks = 0;
  int n_errors = 0;

  mmu_req_arbiter #(.ORDER_DEPTH(8), .ORDER_PTR(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cli_alloc_valid(cli_alloc_valid), .cli_alloc_ready(cli_alloc_ready),
    .cli_alloc_id(cli_alloc_id), .cli_alloc_page_count(cli_alloc_page_count),
    .cli_free_valid(cli_free_valid), .cli_free_ready(cli_free_ready),
    .cli_free_id(cli_free_id), .cli_free_page_idx(cli_free_page_idx),
    .cli_free_page_count(cli_free_page_count),
    .alloc_fifo_push(alloc_fifo_push), .alloc_fifo_id(alloc_fifo_id),
    .alloc_fifo_page_count(alloc_fifo_page_count), .alloc_fifo_full(alloc_fifo_full),
    .free_fifo_push(free_fifo_push), .free_fifo_id(free_fifo_id),
    .free_fifo_page_idx(free_fifo_page_idx), .free_fifo_page_count(free_fifo_page_count),
    .free_fifo_full(free_fifo_full),
    .alloc_rsp_write_en(alloc_rsp_write_en), .alloc_rsp_id(alloc_rsp_id),
    .alloc_rsp_page_idx(alloc_rsp_page_idx), .alloc_rsp_fail(alloc_rsp_fail),
    .alloc_rsp_fail_reason(alloc_rsp_fail_reason),
    .free_rsp_write_en(free_rsp_write_en), .free_rsp_id(free_rsp_id),
    .free_rsp_fail(free_rsp_fail), .free_rsp_fail_reason(free_rsp_fail_reason),
    .cli_alloc_rsp_valid(cli_alloc_rsp_valid), .cli_free_rsp_valid(cli_free_rsp_valid),
    .rsp_id(rsp_id), .rsp_page_idx(rsp_page_idx), .rsp_fail(rsp_fail),
    .rsp_fail_reason(rsp_fail_reason),
    .alloc_outstanding(alloc_outstanding), .free_outstanding(free_outstanding),
    .rsp_orphan_err(rsp_orphan_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cli_alloc_valid = 2'b00; cli_free_valid = 2'b00;
    cli_alloc_id = {8'h22, 8'h11}; cli_alloc_page_count = {2'd2, 2'd1};
    cli_free_id = {8'h44, 8'h33}; cli_free_page_idx = {10'h2BB, 10'h1AA};
    cli_free_page_count = {2'd3, 2'd0};
    alloc_fifo_full = 1'b0; free_fifo_full = 1'b0;
    alloc_rsp_write_en = 1'b0; alloc_rsp_id = '0; alloc_rsp_page_idx = '0;
    alloc_rsp_fail = 1'b0; alloc_rsp_fail_reason = '0;
    free_rsp_write_en = 1'b0; free_rsp_id = '0; free_rsp_fail = 1'b0; free_rsp_fail_reason = '0;
    #2;
    chk("rst_alloc_ready", 32'(cli_alloc_ready), 0);
    chk("rst_alloc_push", 32'(alloc_fifo_push), 0);
    chk("rst_alloc_out", 32'(alloc_outstanding), 0);
    chk("rst_free_out", 32'(free_outstanding), 0);
    chk("rst_strobes", 32'({cli_alloc_rsp_valid, cli_free_rsp_valid}), 0);
    chk("rst_err", 32'(rsp_orphan_err), 0);
    tick(); tick();
    rst_n = 1'b1;

    // alternating grants with responses 3 cycles behind
    for (int i = 0; i < 8; i++) begin
      tick();
      cli_alloc_valid = (i < 4) ? 2'b11 : 2'b00;
      alloc_rsp_write_en = (i >= 3 && i < 7);
      alloc_rsp_id = 8'(i - 3);
      @(negedge clk);
      if (i < 4) begin
        chk("rr_ready", 32'(cli_alloc_ready), (i % 2 == 0) ? 1 : 2);
        chk("rr_fifo_id", 32'(alloc_fifo_id), (i % 2 == 0) ? 'h11 : 'h22);
      end
      if (i >= 4) begin
        chk("rr_strobe", 32'(cli_alloc_rsp_valid), (i % 2 == 0) ? 1 : 2);
        chk("rr_rsp_id", 32'(rsp_id), i - 4);
      end
    end
    tick();
    alloc_rsp_write_en = 1'b0;
    @(negedge clk);
    chk("rr_drained", 32'(alloc_outstanding), 0);
    chk("rr_strobe_idle", 32'(cli_alloc_rsp_valid), 0);

    // full backpressure, then same-cycle grant when it drops
    tick();
    cli_alloc_valid = 2'b11; alloc_fifo_full = 1'b1;
    @(negedge clk);
    chk("full_ready", 32'(cli_alloc_ready), 0);
    chk("full_push", 32'(alloc_fifo_push), 0);
    chk("full_id_zero", 32'(alloc_fifo_id), 0);
    alloc_fifo_full = 1'b0;
    #1;
    chk("unfull_ready", 32'(cli_alloc_ready), 1);
    chk("unfull_push", 32'(alloc_fifo_push), 1);
    chk("unfull_id", 32'(alloc_fifo_id), 'h11);
    chk("unfull_pc", 32'(alloc_fifo_page_count), 1);
    tick();
    cli_alloc_valid = 2'b00;
    alloc_rsp_write_en = 1'b1; alloc_rsp_id = 8'h55; alloc_rsp_page_idx = 10'h123;
    alloc_rsp_fail = 1'b1; alloc_rsp_fail_reason = 2'd2;
    @(negedge clk);
    chk("unfull_out", 32'(alloc_outstanding), 1);
    tick();
    alloc_rsp_write_en = 1'b0;
    @(negedge clk);
    chk("rsp1_strobe", 32'(cli_alloc_rsp_valid), 1);
    chk("rsp1_id", 32'(rsp_id), 'h55);
    chk("rsp1_page", 32'(rsp_page_idx), 'h123);
    chk("rsp1_fail", 32'(rsp_fail), 1);
    chk("rsp1_reason", 32'(rsp_fail_reason), 2);

    // fill the order FIFO to its depth
    for (int i = 0; i < 8; i++) begin
      tick();
      cli_alloc_valid = 2'b11;
      @(negedge clk);
      chk("fill_ready", 32'(cli_alloc_ready), (i % 2 == 0) ? 2 : 1);
    end
    tick();
    @(negedge clk);
    chk("fill_out8", 32'(alloc_outstanding), 8);
    chk("fill_stall_ready", 32'(cli_alloc_ready), 0);
    chk("fill_stall_push", 32'(alloc_fifo_push), 0);
    tick();
    alloc_rsp_write_en = 1'b1; alloc_rsp_id = 8'h77;
    @(negedge clk);
    chk("fill_no_credit", 32'(cli_alloc_ready), 0);
    tick();
    alloc_rsp_write_en = 1'b0;
    @(negedge clk);
    chk("fill_out7", 32'(alloc_outstanding), 7);
    chk("fill_resume", 32'(cli_alloc_ready), 2);
    chk("fill_strobe", 32'(cli_alloc_rsp_valid), 2);
    tick();
    cli_alloc_valid = 2'b00;
    @(negedge clk);
    chk("fill_refull", 32'(alloc_outstanding), 8);
    for (int i = 0; i < 9; i++) begin
      tick();
      alloc_rsp_write_en = (i < 8);
      alloc_rsp_id = 8'(i);
      @(negedge clk);
      if (i > 0) chk("drain_strobe", 32'(cli_alloc_rsp_valid), ((i - 1) % 2 == 0) ? 1 : 2);
    end
    tick();
    alloc_rsp_write_en = 1'b0;
    @(negedge clk);
    chk("drain_out", 32'(alloc_outstanding), 0);

    // simultaneous alloc and free responses
    tick();
    cli_alloc_valid = 2'b01; cli_free_valid = 2'b10;
    @(negedge clk);
    chk("dual_alloc_ready", 32'(cli_alloc_ready), 1);
    chk("dual_free_ready", 32'(cli_free_ready), 2);
    chk("dual_free_push", 32'(free_fifo_push), 1);
    chk("dual_free_id", 32'(free_fifo_id), 'h44);
    chk("dual_free_pidx", 32'(free_fifo_page_idx), 'h2BB);
    chk("dual_free_pc", 32'(free_fifo_page_count), 3);
    tick();
    cli_alloc_valid = 2'b00; cli_free_valid = 2'b00;
    alloc_rsp_write_en = 1'b1; alloc_rsp_id = 8'hA1; alloc_rsp_page_idx = 10'h0AB;
    alloc_rsp_fail = 1'b0; alloc_rsp_fail_reason = 2'd0;
    free_rsp_write_en = 1'b1; free_rsp_id = 8'hB2; free_rsp_fail = 1'b1; free_rsp_fail_reason = 2'd3;
    @(negedge clk);
    tick();
    alloc_rsp_write_en = 1'b0; free_rsp_write_en = 1'b0;
    @(negedge clk);
    chk("dual_t1_alloc", 32'(cli_alloc_rsp_valid), 1);
    chk("dual_t1_free", 32'(cli_free_rsp_valid), 0);
    chk("dual_t1_id", 32'(rsp_id), 'hA1);
    chk("dual_t1_page", 32'(rsp_page_idx), 'h0AB);
    chk("dual_t1_fail", 32'(rsp_fail), 0);
    tick();
    @(negedge clk);
    chk("dual_t2_alloc", 32'(cli_alloc_rsp_valid), 0);
    chk("dual_t2_free", 32'(cli_free_rsp_valid), 2);
    chk("dual_t2_id", 32'(rsp_id), 'hB2);
    chk("dual_t2_page", 32'(rsp_page_idx), 0);
    chk("dual_t2_fail", 32'(rsp_fail), 1);
    chk("dual_t2_reason", 32'(rsp_fail_reason), 3);
    chk("dual_free_out", 32'(free_outstanding), 0);
    tick();
    @(negedge clk);
    chk("dual_t3_idle", 32'({cli_alloc_rsp_valid, cli_free_rsp_valid}), 0);

    // orphan free response
    tick();
    free_rsp_write_en = 1'b1; free_rsp_id = 8'hC3;
    @(negedge clk);
    chk("orph_pre", 32'(rsp_orphan_err), 0);
    tick();
    free_rsp_write_en = 1'b0;
    @(negedge clk);
    chk("orph_set", 32'(rsp_orphan_err), 1);
    chk("orph_no_strobe", 32'({cli_alloc_rsp_valid, cli_free_rsp_valid}), 0);
    chk("orph_out", 32'(free_outstanding), 0);
    tick(); tick(); tick();
    @(negedge clk);
    chk("orph_sticky", 32'(rsp_orphan_err), 1);
    rst_n = 1'b0;
    #1;
    chk("orph_rst_clear", 32'(rsp_orphan_err), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("orph_after_rst", 32'(rsp_orphan_err), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
